// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule constants (PC-1, PC-2, shift schedule, FSM states)
// PC1/PC2 hold FIPS 46-3 bit numbers (1 = MSB of the source vector).
// SHIFT[r] is the left-rotation amount applied to C/D before round r.
package des_pkg;
    localparam int ROUNDS = 16;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [5:0] PC1 [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational DES PC-2 permutation (56-bit C/D -> 48-bit subkey)
// Ports:
//   cd     in  56  C (55:28) and D (27:0) halves, FIPS bit 1 = cd[55]
//   subkey out 48  permuted subkey, FIPS bit 1 = subkey[47]
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);
    // FIPS bits 9,18,22,25,35,38,43,54 are dropped by PC-2
    logic dropped_unused;
    assign dropped_unused = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

    for (genvar i = 0; i < 48; i++) begin : g_bit
        assign subkey[47 - i] = cd[6'd56 - PC2[i]];
    end
endmodule

// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: sequential DES key schedule, one 48-bit subkey per round handshake
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_valid/start_ready key-load handshake (ready only in IDLE)
//   decrypt, key            sampled at start accept (0: K1..K16, 1: K16..K1)
//   round_valid/round_ready subkey handshake with the round datapath
//   round_idx, subkey       handshake count within the job and current subkey
//   last_round              valid round with round_idx == 15
//   done                    one-cycle pulse after the 16th handshake
//   busy                    job in progress (state != IDLE)
module des_key_sched_ctrl
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [3:0]  round_idx,
    output logic [47:0] subkey,
    output logic        last_round,
    output logic        done,
    output logic        busy
);
    state_t      state, state_nx;
    logic [27:0] c, d, c_nx, d_nx;
    logic [3:0]  idx;
    logic        dec, last_idx, two;
    logic [4:0]  r;
    logic [55:0] pc1;

    // Parity bits (FIPS 8,16,...,64) never enter the schedule
    logic parity_unused;
    assign parity_unused = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1[55 - i] = key[~(PC1[i] - 6'd1)];
    end

    assign start_ready = state == IDLE;
    assign round_valid = state == ROUND;
    assign done        = state == DONE;
    assign busy        = state != IDLE;
    assign last_idx    = idx == 4'(ROUNDS - 1);
    assign last_round  = round_valid && last_idx;
    assign round_idx   = idx;

    always_comb begin
        state_nx = (state == IDLE && start_valid) ? ROUND :
                   (state == ROUND && round_ready && last_idx) ? DONE :
                   (state == DONE) ? IDLE : state;
    end

    // Encrypt advances to round idx+2; decrypt steps back from round 16-idx.
    // The idx-15 case is clamped since no rotation happens there.
    always_comb begin
        r    = dec ? 5'd16 - {1'b0, idx} : (last_idx ? 5'd16 : {1'b0, idx} + 5'd2);
        two  = SHIFT[r] == 2'd2;
        c_nx = dec ? (two ? {c[1:0], c[27:2]} : {c[0], c[27:1]})
                   : (two ? {c[25:0], c[27:26]} : {c[26:0], c[27]});
        d_nx = dec ? (two ? {d[1:0], d[27:2]} : {d[0], d[27:1]})
                   : (two ? {d[25:0], d[27:26]} : {d[26:0], d[27]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c   <= '0;
            d   <= '0;
            idx <= '0;
            dec <= 1'b0;
        end else if (start_ready && start_valid) begin
            // Decrypt loads CD0 (== CD16); encrypt pre-rotates to CD1
            dec <= decrypt;
            idx <= '0;
            c   <= decrypt ? pc1[55:28] : {pc1[54:28], pc1[55]};
            d   <= decrypt ? pc1[27:0]  : {pc1[26:0], pc1[27]};
        end else if (round_valid && round_ready) begin
            idx <= idx + 4'd1;
            if (!last_idx) begin
                c <= c_nx;
                d <= d_nx;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c, d}),
        .subkey (subkey)
    );
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb_des_key_sched_ctrl: self-checking bench for des_key_sched_ctrl against a textbook DES key-schedule model
module tb_des_key_sched_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic        round_valid;
    logic        round_ready = 1'b0;
    logic [3:0]  round_idx;
    logic [47:0] subkey;
    logic        last_round;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [47:0] exp_k [16];

    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                       23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48,
                       44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;

    des_key_sched_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .decrypt     (decrypt),
        .key         (key),
        .round_valid (round_valid),
        .round_ready (round_ready),
        .round_idx   (round_idx),
        .subkey      (subkey),
        .last_round  (last_round),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Textbook schedule: cumulative left shifts from PC-1, PC-2 per round,
    // stored in the order the DUT should present them.
    task automatic build(input logic [63:0] k, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] t;
        logic [47:0] sk;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            t  = k >> (64 - pc1_t[i]);
            cd = {cd[54:0], t[0]};
        end
        c = cd[55:28];
        d = cd[27:0];
        for (int rr = 1; rr <= 16; rr++) begin
            for (int s = 0; s < sh_t[rr - 1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            sk = '0;
            for (int i = 0; i < 48; i++) begin
                t  = {8'd0, cd} >> (56 - pc2_t[i]);
                sk = {sk[46:0], t[0]};
            end
            exp_k[dec ? 16 - rr : rr - 1] = sk;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " start_ready"}, start_ready, 1);
        chk({tag, " round_valid"}, round_valid, 0);
        chk({tag, " round_idx"}, round_idx, 0);
        chk({tag, " subkey"}, subkey, 0);
        chk({tag, " last_round"}, last_round, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+18.
    task automatic run_job(input logic [63:0] k, input logic dec, input bit throttle, input bit hold);
        int n, h;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready before start", start_ready, 1);
        build(k, dec);
        start_valid = 1'b1;
        key         = k;
        decrypt     = dec;
        @(negedge clk);
        start_valid = hold;
        h = 0;
        n = 0;
        while (h < 16 && n < 200) begin
            chk("round_valid", round_valid, 1);
            chk("round_idx", round_idx, 64'(h));
            chk("subkey", subkey, exp_k[h]);
            chk("last_round", last_round, 64'(h == 15));
            chk("done in round", done, 0);
            chk("start_ready in round", start_ready, 0);
            key         = {$urandom, $urandom};
            decrypt     = 1'($urandom);
            round_ready = throttle ? 1'($urandom) : 1'b1;
            if (round_ready) h++;
            n++;
            @(negedge clk);
        end
        chk("handshake count", 64'(h), 16);
        chk("done pulse", done, 1);
        chk("round_valid at done", round_valid, 0);
        chk("busy at done", busy, 1);
        chk("start_ready at done", start_ready, 0);
        round_ready = 1'($urandom);
        @(negedge clk);
        chk("done after pulse", done, 0);
        chk("start_ready back", start_ready, 1);
        chk("busy idle", busy, 0);
        chk("round_valid idle", round_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("post reset");

        build(FIPS_KEY, 1'b0);
        chk("model K1", exp_k[0], 64'h1B02EFFC7072);
        chk("model K16", exp_k[15], 64'hCB3D8B0E17F5);

        run_job(FIPS_KEY, 1'b0, 1'b0, 1'b0);
        run_job(FIPS_KEY, 1'b1, 1'b0, 1'b0);

        for (int j = 0; j < 4; j++)
            run_job({$urandom, $urandom}, 1'($urandom), 1'b1, 1'b0);

        // start_valid held high with key toggling, then back-to-back enc/dec
        run_job({$urandom, $urandom}, 1'b0, 1'b1, 1'b1);
        run_job(FIPS_KEY, 1'b0, 1'b0, 1'b1);
        run_job(FIPS_KEY, 1'b1, 1'b0, 1'b0);

        // Abort at round_idx 7
        begin
            int n;
            build({$urandom, $urandom}, 1'b0);
            start_valid = 1'b1;
            key         = {$urandom, $urandom};
            @(negedge clk);
            start_valid = 1'b0;
            round_ready = 1'b1;
            n = 0;
            while (round_idx != 4'd7 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reached idx 7", round_idx, 7);
            rst_n = 1'b0;
            #1;
            chk_reset("async abort");
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("no done while reset", done, 0);
            end
            rst_n = 1'b1;
            @(negedge clk);
            chk("no done after abort", done, 0);
            chk_reset("after abort");
        end

        run_job({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        run_job(FIPS_KEY, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
